// File: rtl/matmul_mem_master_if.sv
// Data-memory bus between the matrix-multiply master and the memory/port mux.
// The master drives address, data and enables, and the memory returns read_data combinationally.
interface matmul_mem_master_if;
    logic        start;
    logic [31:0] read_data;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic        busy;
    logic        done;

    modport master (
        input  start, read_data,
        output address, write_data, write_enable, read_enable, busy, done
    );

    modport slave (
        output start, read_data,
        input  address, write_data, write_enable, read_enable, busy, done
    );
endinterface

// File: rtl/matmul_mem_master.sv
// Data-memory bus master: computes C = A x B for N x N row-major 32-bit matrices in
// memory, one operand read per cycle, and writes C back in row-major order.
module matmul_mem_master #(
    parameter int N      = 3,
    parameter int A_BASE = 0,
    parameter int B_BASE = 9,
    parameter int C_BASE = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    matmul_mem_master_if.master  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] MAC  = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] i, j, k;
    logic [31:0]   acc, a_reg, b_reg;

    // NOTE: every register below uses non-blocking assignment so all updates see
    // the pre-edge values of state and counters, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= RD_A;
                    end
                end
                RD_A: begin
                    a_reg <= bus.read_data;
                    state <= RD_B;
                end
                RD_B: begin
                    b_reg <= bus.read_data;
                    state <= MAC;
                end
                MAC: begin
                    // Product and sum both wrap modulo 2^32.
                    acc <= acc + a_reg * b_reg;
                    if (k == LAST) begin
                        k     <= '0;
                        state <= WR;
                    end else begin
                        k     <= k + CW'(1);
                        state <= RD_A;
                    end
                end
                WR: begin
                    acc <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            state <= FIN;
                        end else begin
                            i     <= i + CW'(1);
                            state <= RD_A;
                        end
                    end else begin
                        j     <= j + CW'(1);
                        state <= RD_A;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: all outputs get a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        bus.address      = '0;
        bus.write_data   = '0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.busy         = (state != IDLE);
        bus.done         = (state == FIN);
        case (state)
            RD_A: begin
                bus.address     = 32'(A_BASE) + 32'(i) * 32'(N) + 32'(k);
                bus.read_enable = 1'b1;
            end
            RD_B: begin
                bus.address     = 32'(B_BASE) + 32'(k) * 32'(N) + 32'(j);
                bus.read_enable = 1'b1;
            end
            WR: begin
                bus.address      = 32'(C_BASE) + 32'(i) * 32'(N) + 32'(j);
                bus.write_data   = acc;
                bus.write_enable = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_mem_master.sv
// Bench for matmul_mem_master: word memory model, arithmetic reference for C,
// and cycle-exact checks of write order, busy and done.
module tb_matmul_mem_master;
    localparam int N      = 3;
    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int C_BASE = 18;
    localparam int NN     = N * N;
    localparam int E      = 3 * N + 1;   // cycles per C element
    localparam int P      = NN * E + 1;  // cycles from start edge to FIN inclusive

    logic clk;
    logic reset;
    matmul_mem_master_if bus ();

    matmul_mem_master #(.N(N), .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];
    assign bus.read_data = bus.read_enable ? mem[bus.address[5:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mat_a [NN];
    logic [31:0] mat_b [NN];
    logic [31:0] mat_c [NN];

    int          wr_cyc  [$];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          done_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: textbook triple loop in 32-bit arithmetic.
    task automatic compute_ref();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                logic [31:0] s;
                s = 32'h0;
                for (int t = 0; t < N; t++) s = s + mat_a[r*N+t] * mat_b[t*N+c];
                mat_c[r*N+c] = s;
            end
    endtask

    task automatic load_mem();
        for (int x = 0; x < 64; x++) mem[x] = 32'hDEAD_BEEF;
        for (int x = 0; x < NN; x++) begin
            mem[A_BASE + x] = mat_a[x];
            mem[B_BASE + x] = mat_b[x];
        end
        compute_ref();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, bus.address, 32'h0);
        check({tag, "_wdata"}, bus.write_data, 32'h0);
        check({tag, "_we"}, 32'(bus.write_enable), 32'h0);
        check({tag, "_re"}, 32'(bus.read_enable), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
    endtask

    task automatic fire_start();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    // Cycle c is the clock period following the c-th edge after the start edge.
    task automatic run(input int ncyc, input bit hold, input bit pulses, input int reset_at);
        logic        pend;
        logic [31:0] pa, pd;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            check("excl", 32'(bus.read_enable && bus.write_enable), 32'h0);
            if (!bus.read_enable && !bus.write_enable) begin
                check("addr_idle", bus.address, 32'h0);
                check("wdata_idle", bus.write_data, 32'h0);
            end
            check("busy", 32'(bus.busy), 32'((c <= P) || (hold && c >= P + 2 && c <= 2 * P + 1)));
            if (bus.write_enable) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(bus.address);
                wr_data.push_back(bus.write_data);
            end
            if (bus.done) done_cyc.push_back(c);
            pend = bus.write_enable;
            pa   = bus.address;
            pd   = bus.write_data;
            bus.start = (hold && c <= 2 * P) || (pulses && (c == 5 || c == 50 || c == P));
            if (c == reset_at) begin
                #2 reset = 1'b1;
                #1 check_idle_outputs("async_rst");
                break;
            end
            @(posedge clk);
            if (pend) mem[pa[5:0]] = pd;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_writes(input int off, input int first, input int count);
        for (int m = 0; m < count; m++) begin
            if (first + m < wr_cyc.size()) begin
                check("wr_cycle", 32'(wr_cyc[first+m]), 32'(off + E * (m + 1)));
                check("wr_addr", wr_addr[first+m], 32'(C_BASE + m));
                check("wr_data", wr_data[first+m], mat_c[m]);
            end
        end
    endtask

    task automatic check_mem_c();
        for (int m = 0; m < NN; m++) check("mem_c", mem[C_BASE + m], mat_c[m]);
    endtask

    task automatic full_run_check(input bit pulses);
        fire_start();
        run(P + 2, 1'b0, pulses, 0);
        check("wr_count", 32'(wr_cyc.size()), 32'(NN));
        check_writes(0, 0, NN);
        check("done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("done_cycle", 32'(done_cyc[0]), 32'(P));
        check_mem_c();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int x = 0; x < 64; x++) mem[x] = 32'h0;
        #3 check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Rows [1,2,3] for both A and B.
        for (int x = 0; x < NN; x++) begin
            mat_a[x] = 32'(x % N + 1);
            mat_b[x] = 32'(x % N + 1);
        end
        load_mem();
        full_run_check(1'b0);
        check("c00_const", mem[C_BASE], 32'd6);
        check("c22_const", mem[C_BASE + 8], 32'd18);

        // Identity times 1..9.
        for (int x = 0; x < NN; x++) begin
            mat_a[x] = 32'(x / N == x % N);
            mat_b[x] = 32'(x + 1);
        end
        load_mem();
        full_run_check(1'b0);
        check("ident_c5", mem[C_BASE + 5], 32'd6);

        // Wrap-around: 2^16 * 2^16 and (2^32-1)^2.
        for (int x = 0; x < NN; x++) begin mat_a[x] = 32'h0; mat_b[x] = 32'h0; end
        mat_a[0] = 32'h0001_0000;
        mat_b[0] = 32'h0001_0000;
        load_mem();
        full_run_check(1'b0);
        check("wrap_zero", mem[C_BASE], 32'h0);
        mat_a[0] = 32'hFFFF_FFFF;
        mat_b[0] = 32'hFFFF_FFFF;
        load_mem();
        full_run_check(1'b0);
        check("wrap_one", mem[C_BASE], 32'h1);

        // Random operands with start pulses during the run and in FIN.
        for (int x = 0; x < NN; x++) begin mat_a[x] = $urandom; mat_b[x] = $urandom; end
        load_mem();
        full_run_check(1'b1);

        // Asynchronous reset mid-run, then a clean restart.
        for (int x = 0; x < NN; x++) begin mat_a[x] = $urandom; mat_b[x] = $urandom; end
        load_mem();
        fire_start();
        run(45, 1'b0, 1'b0, 45);
        check("rst_wr_count", 32'(wr_cyc.size()), 32'd4);
        for (int m = 0; m < NN; m++)
            check("rst_mem", mem[C_BASE + m], (m < 4) ? mat_c[m] : 32'hDEAD_BEEF);
        @(negedge clk);
        reset = 1'b0;
        full_run_check(1'b0);

        // start held high: two back-to-back runs.
        for (int x = 0; x < NN; x++) begin mat_a[x] = $urandom_range(0, 1000); mat_b[x] = $urandom; end
        load_mem();
        fire_start();
        run(2 * P + 3, 1'b1, 1'b0, 0);
        check("hold_wr_count", 32'(wr_cyc.size()), 32'(2 * NN));
        check_writes(0, 0, NN);
        check_writes(P + 1, NN, NN);
        check("hold_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() > 1) begin
            check("hold_done0", 32'(done_cyc[0]), 32'(P));
            check("hold_done1", 32'(done_cyc[1]), 32'(2 * P + 1));
        end
        check_mem_c();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
